// File: rtl/lagarto_rst_pkg.sv
// Shared types and defaults for the Lagarto tile reset sequencer.
// Enum encodings are visible on seq_state_o, so keep them stable.
package lagarto_rst_pkg;

  typedef enum logic [1:0] {
    WAKE    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SYNC = 2'd2
  } soft_state_e;

  localparam int DEF_WAKE_CYCLES    = 32768;
  localparam int DEF_STAGGER_CYCLES = 16;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_SOFT_RST_MIN   = 8;

  // Counter value (edge number) at which hart idx gets its release.
  function automatic int release_at(input int wake, input int stagger, input int idx);
    return wake + idx * stagger;
  endfunction

endpackage

// File: rtl/lagarto_rst_sync.sv
// Reset release synchronizer: asynchronous assert on reset_l, synchronous deassert,
// plus a synchronous clear used to pull a running hart back into reset.
module lagarto_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_l,
  input  logic clear,
  input  logic rel,
  output logic rst_l,
  output logic rst_l_pre
);

  if (STAGES < 2) begin : g_bad_stages
    $error("lagarto_rst_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      chain_reg <= '0;
    end else if (clear) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], rel};
    end
  end

  // rst_l_pre high means rst_l rises on the next edge.
  assign rst_l     = chain_reg[STAGES-1];
  assign rst_l_pre = chain_reg[STAGES-2];

endmodule

// File: rtl/lagarto_reset_sequencer.sv
// Multi-hart reset sequencer: programmable wake-up delay, staggered per-hart release
// through reset synchronizers, and per-hart soft reset request/ack.
module lagarto_reset_sequencer
  import lagarto_rst_pkg::*;
#(
  parameter int NUM_HARTS      = 1,
  parameter int WAKE_CYCLES    = DEF_WAKE_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int SOFT_RST_MIN   = DEF_SOFT_RST_MIN
) (
  input  logic                 clk_i,
  input  logic                 reset_l,
  input  logic [NUM_HARTS-1:0] soft_rst_req_i,
  output logic [NUM_HARTS-1:0] soft_rst_ack_o,
  output logic [NUM_HARTS-1:0] hart_rst_l_o,
  output logic                 all_released_o,
  output logic [1:0]           seq_state_o
);

  localparam int LAST_REL = release_at(WAKE_CYCLES, STAGGER_CYCLES, NUM_HARTS - 1);
  localparam int CNT_W    = $clog2(LAST_REL + 1);
  localparam int HOLD_W   = $clog2(SOFT_RST_MIN + 1);

  if (NUM_HARTS < 1) begin : g_bad_harts
    $error("lagarto_reset_sequencer: NUM_HARTS must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("lagarto_reset_sequencer: WAKE_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 0) begin : g_bad_stagger
    $error("lagarto_reset_sequencer: STAGGER_CYCLES must be >= 0");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("lagarto_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (SOFT_RST_MIN < 1) begin : g_bad_soft
    $error("lagarto_reset_sequencer: SOFT_RST_MIN must be >= 1");
  end

  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  seq_state_e           seq_reg, seq_next;
  logic                 all_rel_reg, all_rel_next;
  logic [NUM_HARTS-1:0] hart_rst_l, hart_pre;

  // Saturating counter; cnt_next is the edge number being completed.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_reg != CNT_W'(LAST_REL)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    seq_next = seq_reg;
    case (seq_reg)
      WAKE: begin
        if (cnt_next >= CNT_W'(WAKE_CYCLES)) begin
          seq_next = (LAST_REL == WAKE_CYCLES) ? RUN : STAGGER;
        end
      end
      STAGGER: begin
        if (cnt_next >= CNT_W'(LAST_REL)) begin
          seq_next = RUN;
        end
      end
      RUN:     seq_next = RUN;
      default: seq_next = WAKE;
    endcase
    all_rel_next = (seq_reg == RUN) && (&hart_rst_l);
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      cnt_reg     <= '0;
      seq_reg     <= WAKE;
      all_rel_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      seq_reg     <= seq_next;
      all_rel_reg <= all_rel_next;
    end
  end

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    localparam int REL_AT = release_at(WAKE_CYCLES, STAGGER_CYCLES, gi);

    soft_state_e       soft_reg, soft_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              rel_reg, ack_reg, ack_next;
    logic              sync_clear, sync_d;

    always_comb begin
      soft_next  = soft_reg;
      hold_next  = hold_reg;
      sync_clear = 1'b0;
      ack_next   = 1'b0;
      case (soft_reg)
        IDLE: begin
          if (soft_rst_req_i[gi] && hart_rst_l[gi]) begin
            soft_next  = HOLD;
            hold_next  = '0;
            sync_clear = 1'b1;
          end
        end
        HOLD: begin
          if (hold_reg != HOLD_W'(SOFT_RST_MIN - 1)) begin
            hold_next = hold_reg + HOLD_W'(1);
          end else if (!soft_rst_req_i[gi]) begin
            soft_next = SYNC;
          end
        end
        SYNC: begin
          // Ack lands on the same edge the hart comes out of reset.
          if (hart_pre[gi]) begin
            soft_next = IDLE;
            ack_next  = 1'b1;
          end
        end
        default: soft_next = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
        rel_reg  <= 1'b0;
        soft_reg <= IDLE;
        hold_reg <= '0;
        ack_reg  <= 1'b0;
      end else begin
        rel_reg  <= rel_reg | (cnt_next >= CNT_W'(REL_AT));
        soft_reg <= soft_next;
        hold_reg <= hold_next;
        ack_reg  <= ack_next;
      end
    end

    assign sync_d = rel_reg && (soft_reg != HOLD);

    lagarto_rst_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i     (clk_i),
      .reset_l   (reset_l),
      .clear     (sync_clear),
      .rel       (sync_d),
      .rst_l     (hart_rst_l[gi]),
      .rst_l_pre (hart_pre[gi])
    );

    assign soft_rst_ack_o[gi] = ack_reg;
  end

  assign hart_rst_l_o   = hart_rst_l;
  assign all_released_o = all_rel_reg;
  assign seq_state_o    = seq_reg;

endmodule

// File: tb/tb_lagarto_reset_sequencer.sv
// Directed bench: POR timing for staggered and simultaneous release, soft reset
// pulse/long hold/parallel/re-request, and asynchronous reset mid-sequence.
module tb_lagarto_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] ack, hart;
  logic       all_rel;
  logic [1:0] st;
  logic [2:0] req0 = '0;
  logic [2:0] ack0, hart0;
  logic       all_rel0;
  logic [1:0] st0;
  int         n_total = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  lagarto_reset_sequencer #(
    .NUM_HARTS(4), .WAKE_CYCLES(64), .STAGGER_CYCLES(8), .SYNC_STAGES(2), .SOFT_RST_MIN(8)
  ) u_dut (
    .clk_i(clk), .reset_l(reset_l), .soft_rst_req_i(req), .soft_rst_ack_o(ack),
    .hart_rst_l_o(hart), .all_released_o(all_rel), .seq_state_o(st)
  );

  lagarto_reset_sequencer #(
    .NUM_HARTS(3), .WAKE_CYCLES(64), .STAGGER_CYCLES(0), .SYNC_STAGES(2), .SOFT_RST_MIN(8)
  ) u_dut0 (
    .clk_i(clk), .reset_l(reset_l), .soft_rst_req_i(req0), .soft_rst_ack_o(ack0),
    .hart_rst_l_o(hart0), .all_released_o(all_rel0), .seq_state_o(st0)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [15:0] pack(input logic [1:0] s, input logic a,
                                       input logic [3:0] k, input logic [3:0] h);
    return {5'b0, s, a, k, h};
  endfunction

  function automatic logic [15:0] dv();
    return pack(st, all_rel, ack, hart);
  endfunction

  function automatic logic [15:0] dv0();
    return pack(st0, all_rel0, {1'b0, ack0}, {1'b0, hart0});
  endfunction

  // Called at a negedge with reset_l just released; edge k is the k-th rising edge.
  // early: req[0] is held high through WAKE and dropped after edge 95.
  task automatic por_run(input bit early, input int last_k);
    logic [3:0] eh, ea;
    logic [1:0] es;
    logic       er;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) eh[i] = (k >= 66 + 8 * i);
      ea = '0;
      er = (k >= 91);
      if (early) begin
        eh[0] = (k == 66) || (k >= 98);
        ea[0] = (k == 98);
        er    = (k >= 99);
      end
      es = (k >= 88) ? 2'd2 : (k >= 64) ? 2'd1 : 2'd0;
      check($sformatf("por e%0d", k), dv(), pack(es, er, ea, eh));
      check($sformatf("por0 e%0d", k), dv0(),
            pack((k >= 64) ? 2'd2 : 2'd0, k >= 67, 4'b0, (k >= 66) ? 4'b0111 : 4'b0));
      if (early && k == 95) req[0] = 1'b0;
    end
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2 reset_l = 1'b0;
    #1;
    check({tag, " dut"}, dv(), 16'h0);
    check({tag, " dut0"}, dv0(), 16'h0);
  endtask

  initial begin
    logic [3:0] eh, ea;
    logic       er;

    repeat (3) @(negedge clk);
    check("reset dut", dv(), 16'h0);
    check("reset dut0", dv0(), 16'h0);
    reset_l = 1'b1;
    por_run(1'b0, 95);

    // Single-cycle request on hart 1.
    req[1] = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      @(posedge clk);
      @(negedge clk);
      eh = 4'b1111; eh[1] = (j >= 10);
      ea = '0;      ea[1] = (j == 10);
      er = (j == 0) || (j >= 11);
      check($sformatf("soft1 j%0d", j), dv(), pack(2'd2, er, ea, eh));
      if (j == 0) req[1] = 1'b0;
    end

    // Request on hart 2 held for 20 cycles.
    req[2] = 1'b1;
    for (int j = 0; j <= 25; j++) begin
      @(posedge clk);
      @(negedge clk);
      eh = 4'b1111; eh[2] = (j >= 22);
      ea = '0;      ea[2] = (j == 22);
      er = (j == 0) || (j >= 23);
      check($sformatf("hold2 j%0d", j), dv(), pack(2'd2, er, ea, eh));
      if (j == 19) req[2] = 1'b0;
    end

    // Harts 0 and 3 requested on the same edge.
    req[0] = 1'b1;
    req[3] = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      @(posedge clk);
      @(negedge clk);
      eh = 4'b1111; eh[0] = (j >= 10); eh[3] = (j >= 10);
      ea = '0;      ea[0] = (j == 10); ea[3] = (j == 10);
      er = (j == 0) || (j >= 11);
      check($sformatf("par03 j%0d", j), dv(), pack(2'd2, er, ea, eh));
      if (j == 0) begin
        req[0] = 1'b0;
        req[3] = 1'b0;
      end
    end

    // Hart 1 re-requested so the request is high on the ack edge.
    req[1] = 1'b1;
    for (int j = 0; j <= 24; j++) begin
      @(posedge clk);
      @(negedge clk);
      eh = 4'b1111; eh[1] = (j == 10) || (j >= 21);
      ea = '0;      ea[1] = (j == 10) || (j == 21);
      er = (j == 0) || (j == 11) || (j >= 22);
      check($sformatf("rereq1 j%0d", j), dv(), pack(2'd2, er, ea, eh));
      if (j == 0)  req[1] = 1'b0;
      if (j == 9)  req[1] = 1'b1;
      if (j == 11) req[1] = 1'b0;
    end

    // Restart, then abort during STAGGER.
    reset_l = 1'b0;
    #1;
    check("rst run dut", dv(), 16'h0);
    @(negedge clk);
    reset_l = 1'b1;
    por_run(1'b0, 70);
    async_reset_check("rst stagger");
    @(negedge clk);
    reset_l = 1'b1;
    por_run(1'b0, 95);

    // Abort during HOLD on hart 1; rerun POR with req[0] held through WAKE.
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    check("hold before rst", dv(), pack(2'd2, 1'b1, 4'b0, 4'b1101));
    @(posedge clk);
    async_reset_check("rst hold");
    req[0] = 1'b1;
    @(negedge clk);
    reset_l = 1'b1;
    por_run(1'b1, 100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
